dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, 256, number of 64-bit doublewords in the backing array (power of two).
REQ-002 Parameter BASE, 64'h8000_0000, byte address of doubleword 0.
REQ-003 Parameter LATENCY, 2, WAIT cycles between acceptance and array access (0..15).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_wen  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  64  byte address; bits [2:0] ignored for indexing.
REQ-010 req_wdata  in  64  store data, already lane-aligned.
REQ-011 req_wstrb  in  8  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-012 resp_valid  out  1  response present.
REQ-013 resp_ready  in  1  initiator accepts the response.
REQ-014 resp_rdata  out  64  full aligned doubleword for loads; 0 for stores.
REQ-015 resp_err  out  1  access was out of range.

Function
REQ-016 States IDLE, WAIT, RESP; req_ready = (state == IDLE); resp_valid = (state == RESP).
REQ-017 Acceptance: req_valid & req_ready on an edge; req_wen, index, wdata and wstrb are captured in that edge.
REQ-018 On acceptance, go IDLE->WAIT with counter = LATENCY-1 if LATENCY > 0, else IDLE->RESP directly.
REQ-019 In WAIT, decrement the counter each cycle; leave WAIT for RESP on the edge where the counter is 0.
REQ-020 Array access occurs on the edge entering RESP: a load registers the doubleword into resp_rdata; a store updates only the strobed lanes.
REQ-021 Load-to-response latency is LATENCY+1 cycles from the acceptance edge; one request is outstanding at most.
REQ-022 RESP holds resp_rdata and resp_err stable until resp_valid & resp_ready, then returns to IDLE; the next request is accepted no earlier than the following edge.
REQ-023 index = (req_addr - BASE) >> 3, width $clog2(DEPTH); the subtraction is 64-bit modular.
REQ-024 A store with req_wstrb = 0 leaves the array unchanged and still produces a response.
REQ-025 A load immediately following a store to the same doubleword returns the post-store data; no bypass is needed because accesses are serialized.
REQ-026 Inputs are ignored outside IDLE; req_* may change freely while req_ready = 0.

Reset
REQ-027 With rst high on an edge, the block goes to IDLE with counter = 0, resp_rdata = 0, resp_err = 0, req_ready = 1 after the edge, and resp_valid = 0.
REQ-028 A reset during WAIT or RESP aborts the transaction with no response; a store not yet applied is discarded.
REQ-029 Array contents are not reset.

Configuration
REQ-030 With DMEM_RANGE_CHK_EN defined, a request whose (req_addr - BASE) >= DEPTH*8 sets resp_err = 1 and resp_rdata = 0, and a store does not write; timing is unchanged.
REQ-031 Without DMEM_RANGE_CHK_EN, resp_err is tied to 0 and the index wraps modulo DEPTH.

Structure
REQ-032 The shared package holds the state enum (IDLE/WAIT/RESP), DEFAULT_BASE, and the byte-strobe merge function.
REQ-033 One sub-module, dmem_array, holds the DEPTH x 64 storage with one synchronous read/write port and a per-byte write enable; FSM and counter stay in dmem_resp.

Verification
REQ-034 LATENCY=2, store addr 8000_0010, wdata 1122334455667788, wstrb FF, then load at the same address -> load resp_valid rises 3 cycles after acceptance with rdata 1122334455667788 and err 0.
REQ-035 After the REQ-034 store, store wstrb 0x0C with wdata 0000_0000_AABB_0000 at 8000_0010, then load -> rdata 11223344AABB7788.
REQ-036 Hold resp_ready low 5 cycles in RESP -> resp_valid and rdata are stable, req_ready stays 0, and a new req_valid is not accepted.
REQ-037 With DMEM_RANGE_CHK_EN, store at 8000_0800 (DEPTH=256) then load at 8000_0000 -> the store returns err=1, and doubleword 0 is unchanged.
REQ-038 Assert rst in WAIT of a store -> next cycle state is IDLE with resp_valid 0, and a later load of that address returns the old data.
REQ-039 LATENCY=0 with back-to-back loads and resp_ready held at 1 -> one response every 2 cycles, each 1 cycle after its acceptance.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for the dmem_resp data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [63:0] DEFAULT_BASE = 64'h8000_0000;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_data,
                                              input logic [63:0] new_data,
                                              input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_data;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage: one synchronous read/write port with per-byte write enables.
module dmem_array
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          wen,
  input  logic [IW-1:0] idx,
  input  logic [63:0]   wdata,
  input  logic [7:0]    wstrb,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  // NOTE: storage has no reset; clearing every word would force flops instead of a RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) mem[idx] <= merge_bytes(mem[idx], wdata, wstrb);
      else     rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Single-outstanding data-memory responder with programmable wait latency.
// Optional out-of-range detection is enabled by defining DMEM_RANGE_CHK_EN.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH   = 256,
  parameter logic [63:0] BASE    = DEFAULT_BASE,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t        state;
  logic [3:0]    cnt;
  logic          wen_q;
  logic [IW-1:0] idx_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wstrb_q;
  logic          err_q;
  logic          load_q;
  logic          resp_err_q;
  logic [63:0]   arr_rdata;

  logic [63:0]   offset;
  logic [IW-1:0] req_idx;
  logic          req_err;
  logic          unused_bits;

  assign offset  = req_addr - BASE;
  assign req_idx = offset[IW+2:3];
`ifdef DMEM_RANGE_CHK_EN
  assign req_err     = |offset[63:IW+3];
  assign unused_bits = ^offset[2:0];
`else
  assign req_err     = 1'b0;
  assign unused_bits = ^{offset[63:IW+3], offset[2:0]};
`endif

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  logic accept;
  assign accept = req_valid && (state == IDLE);

  // The array is touched on the edge entering RESP; with zero latency that is
  // the acceptance edge itself, so the live request feeds the port directly.
  logic          access;
  logic          use_live;
  logic          a_wen;
  logic [IW-1:0] a_idx;
  logic [63:0]   a_wdata;
  logic [7:0]    a_wstrb;
  logic          a_err;

  assign use_live = (state == IDLE);
  assign a_wen    = use_live ? req_wen   : wen_q;
  assign a_idx    = use_live ? req_idx   : idx_q;
  assign a_wdata  = use_live ? req_wdata : wdata_q;
  assign a_wstrb  = use_live ? req_wstrb : wstrb_q;
  assign a_err    = use_live ? req_err   : err_q;
  assign access   = !rst && ((accept && (LATENCY == 0)) ||
                             ((state == WAIT) && (cnt == 4'd0)));

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (access && !a_err),
    .wen   (a_wen),
    .idx   (a_idx),
    .wdata (a_wdata),
    .wstrb (a_wstrb),
    .rdata (arr_rdata)
  );

  // Request capture is pure datapath and needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      idx_q   <= req_idx;
      wdata_q <= req_wdata;
      wstrb_q <= req_wstrb;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      load_q     <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state      <= RESP;
              load_q     <= !req_wen && !req_err;
              resp_err_q <= req_err;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            load_q     <= !wen_q && !err_q;
            resp_err_q <= err_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stores and rejected loads answer with zero data.
  assign resp_rdata = load_q ? arr_rdata : 64'd0;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: random traffic against a byte-array memory model.
module tb_dmem_resp;
  import dmem_resp_pkg::*;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;

  logic        req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0;
  logic [63:0] resp_rdata0;

  dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_resp #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid0), .resp_ready(resp_ready0),
    .resp_rdata(resp_rdata0), .resp_err(resp_err0)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model [DEPTH];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          bp_en    = 0;
  bit          hold_low = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int model_idx(input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    return int'((off / 8) % DEPTH);
  endfunction

  function automatic bit model_err(input logic [63:0] addr);
`ifdef DMEM_RANGE_CHK_EN
    return (addr - BASE) >= 64'(DEPTH * 8);
`else
    return 1'b0;
`endif
  endfunction

  // Present one request, wait for acceptance, then update the model and scoreboard.
  task automatic issue(input bit wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wstrb, input bit track);
    bit   ok = 0;
    exp_t e;
    int   idx;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wen   = 1'($urandom_range(0, 1));
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    req_wstrb = 8'($urandom);
    if (track) begin
      idx   = model_idx(addr);
      e.err = model_err(addr);
      if (wen) begin
        e.rdata = 64'd0;
        if (!e.err)
          for (int b = 0; b < 8; b++)
            if (wstrb[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        e.rdata = e.err ? 64'd0 : model[idx];
      end
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      resp_ready = hold_low ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: latency, hold stability and scoreboard comparison for the main instance.
  initial begin
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          seen = 0;
    logic [63:0] held_rdata;
    logic        held_err;
    exp_t        e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        seen = 0;
      end else begin
        if (req_valid && req_ready) acc_cyc = cyc;
        if (resp_valid) begin
          check("req_ready_in_resp", 64'(req_ready), 64'd0);
          if (!seen) begin
            seen = 1;
            check("latency", 64'(cyc - acc_cyc), 64'(LAT + 1));
            held_rdata = resp_rdata;
            held_err   = resp_err;
          end else begin
            check("hold_rdata", resp_rdata, held_rdata);
            check("hold_err", 64'(resp_err), 64'(held_err));
          end
          if (resp_ready) begin
            seen = 0;
            if (sb.size() == 0) begin
              check("unexpected_resp", 64'd1, 64'd0);
            end else begin
              e = sb.pop_front();
              check("rdata", resp_rdata, e.rdata);
              check("err", 64'(resp_err), 64'(e.err));
            end
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] d0;
    bit          ok;
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    req_valid0 = 1'b0; resp_ready0 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_resp_valid0", 64'(resp_valid0), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      issue(1'b1, BASE + 64'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b1);

    // Full store, partial-lane store, empty-strobe store, each followed by a load.
    issue(1'b1, BASE + 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    issue(1'b0, BASE + 64'h10, 64'd0, 8'h00, 1'b1);
    issue(1'b1, BASE + 64'h10, 64'h0000_0000_AABB_0000, 8'h0C, 1'b1);
    issue(1'b0, BASE + 64'h10, 64'd0, 8'h00, 1'b1);
    issue(1'b1, BASE + 64'h18, {$urandom, $urandom}, 8'h00, 1'b1);
    issue(1'b0, BASE + 64'h18, 64'd0, 8'h00, 1'b1);
    issue(1'b1, BASE + 64'h800, {$urandom, $urandom}, 8'hFF, 1'b1);
    issue(1'b0, BASE, 64'd0, 8'h00, 1'b1);

    bp_en = 1;
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a;
      case ($urandom_range(0, 7))
        0:       a = {$urandom, $urandom};
        1:       a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 4095));
        default: a = BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
      endcase
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), 1'b1);
    end
    bp_en = 0;
    drain();

    // Backpressure: response held five cycles while another request waits.
    hold_low = 1;
    @(posedge clk);
    issue(1'b0, BASE + 64'h20, 64'd0, 8'h00, 1'b1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; break; end
    end
    check("hold_resp_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 64'h28;
    req_wdata = ~model[5]; req_wstrb = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      check("hold_req_ready", 64'(req_ready), 64'd0);
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; hold_low = 0;
    issue(1'b0, BASE + 64'h28, 64'd0, 8'h00, 1'b1);
    drain();

    // Reset during WAIT of a store discards it.
    issue(1'b1, BASE + 64'h40, ~model[8], 8'hFF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rdata", resp_rdata, 64'd0);
    repeat (4) begin
      @(negedge clk);
      check("abort_no_resp", 64'(resp_valid), 64'd0);
    end
    issue(1'b0, BASE + 64'h40, 64'd0, 8'h00, 1'b1);
    drain();

    // Zero-latency instance: store then back-to-back loads with resp_ready held high.
    d0 = {$urandom, $urandom};
    @(posedge clk); #1;
    req_valid0 = 1'b1; req_wen = 1'b1; req_addr = BASE; req_wdata = d0; req_wstrb = 8'hFF;
    resp_ready0 = 1'b1;
    @(negedge clk);
    check("b2b_first_ready", 64'(req_ready0), 64'd1);
    @(posedge clk); #1 req_wen = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("b2b_valid", 64'(resp_valid0), 64'(k % 2));
      check("b2b_ready", 64'(req_ready0), 64'((k + 1) % 2));
      if (k % 2 == 1) begin
        check("b2b_rdata", resp_rdata0, (k == 1) ? 64'd0 : d0);
        check("b2b_err", 64'(resp_err0), 64'd0);
      end
    end
    @(posedge clk); #1 req_valid0 = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
